ucore_uart_arbiter: RTL
=======================

Name: ucore_uart_arbiter

Overview:
- Shares the single ucore UART read/write channel (rcen/rack, wcen/wack) between NREQ internal requesters, e.g. microcode sequencer and debug/DMA engine.
- Round-robin grant; one transaction in flight; holds the UART strobe until acknowledged or timed out.
- Returns read data and completion status to the granted requester.
- Sits between the requesters and the UART port pins of ucore_main.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 255, cycles of strobe without ack before abort (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request level
req_write  in  NREQ  1=write, 0=read
req_cen  in  NREQ*8  per-requester channel enables, requester i at [8i+7:8i]
req_wdata  in  NREQ*8  per-requester write data, same packing
req_done  out  NREQ  one-cycle completion pulse, one-hot
req_err  out  1  valid with req_done; 1=timeout or zero cen
req_rdata  out  8  valid with req_done on reads; 0 on writes/errors
uart_rcen  out  8  UART read channel enables
uart_rack  in  1  UART read acknowledge, rdata valid same cycle
uart_rdata  in  8  UART read data
uart_wcen  out  8  UART write channel enables
uart_wack  in  1  UART write acknowledge
uart_wdata  out  8  UART write data
uart_interrupt  in  1  UART interrupt level
irq_pending  out  1  sticky: rising edge of uart_interrupt seen
irq_clear  in  1  clears irq_pending

Behaviour:
- Reset values: state IDLE, all outputs 0, last_grant=NREQ-1 (requester 0 wins first), timeout counter 0, registered interrupt sample 0.
- All outputs registered.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: if any req_valid, pick first valid index scanning from last_grant+1 mod NREQ upward with wrap. Latch id, cen, wdata, write; set last_grant=id.
  - Latched cen==0: go DONE with err=1, UART untouched.
  - Otherwise go WRITE if write, else READ.
  - No valid: stay.
- READ: uart_rcen=latched cen, uart_wcen=0.
  - uart_rack=1: capture uart_rdata, err=0, go DONE; uart_rcen drops to 0 next cycle.
  - Counter increments each READ cycle without ack; reaching TIMEOUT with no ack: err=1, rdata=0, go DONE.
  - uart_wack ignored in READ.
- WRITE: mirror of READ using uart_wcen/uart_wdata/uart_wack, with uart_wdata held stable while in WRITE. uart_rack ignored.
- DONE: exactly one cycle. req_done[id]=1, req_err and req_rdata valid. Next state IDLE; counter cleared.
- Requester protocol:
  - Hold valid/write/cen/wdata stable from assertion until its req_done pulse.
  - Deassert valid at the edge ending the done cycle unless issuing a back-to-back request.
  - req_valid is sampled only in IDLE; changes in other states are ignored.
- Latency: valid sampled in IDLE at edge t -> strobe visible cycle t+1 -> ack at edge t+1 earliest -> done visible cycle t+2. Minimum 3 cycles valid-to-done; throughput one transaction per 3 cycles.
- Ack arriving same cycle the counter reaches TIMEOUT: ack wins, err=0.
- Acks in IDLE/DONE (spurious) are ignored and have no effect.
- Both acks high in READ: only rack honoured.
- Round-robin fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
- Reset mid-transaction: at the reset edge the FSM goes to IDLE, strobes drop, no req_done is issued, and last_grant is restored to NREQ-1.
- Interrupt:
  - irq_pending sets on a cycle where uart_interrupt=1 and its previous registered sample=0.
  - irq_clear clears it.
  - Simultaneous set and clear: set wins.

Test Plan:
- Single read: req0 valid, read, cen=8'h01; UART returns rack after 2 cycles with rdata=8'hA5 -> uart_rcen=8'h01 for 3 cycles, req_done=2'b01, err=0, req_rdata=8'hA5.
- Write: req1 write cen=8'h02 wdata=8'h3C, wack after 1 cycle -> uart_wcen=8'h02, uart_wdata=8'h3C while strobed; req_done=2'b10, err=0, rdata=0.
- Round-robin: both valid, back-to-back reads with immediate ack -> grant order 0,1,0,1; no requester served twice consecutively.
- Timeout: TIMEOUT=4, no ack -> strobe held 4 cycles, done with err=1, rdata=0.
- Zero cen (req_cen=8'h00) -> no UART strobe, done with err=1. Ack on the TIMEOUT cycle -> err=0.
- Reset during READ -> strobes 0 next cycle, no req_done. Interrupt 0->1 -> irq_pending=1; irq_clear on the same cycle as a new rising edge -> stays 1.

Source files
------------

// File: rtl/ucore_uart_arbiter_if.sv
// Requester-side and UART-side signal bundle for the ucore UART arbiter.
// slave is the arbiter's view; master is the view of the requesters and UART pins.
`timescale 1ns/1ps
interface ucore_uart_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*8-1:0] req_cen;
    logic [NREQ*8-1:0] req_wdata;
    logic [NREQ-1:0]   req_done;
    logic              req_err;
    logic [7:0]        req_rdata;
    logic [7:0]        uart_rcen;
    logic              uart_rack;
    logic [7:0]        uart_rdata;
    logic [7:0]        uart_wcen;
    logic              uart_wack;
    logic [7:0]        uart_wdata;
    logic              uart_interrupt;
    logic              irq_pending;
    logic              irq_clear;

    modport slave (
        input  req_valid, req_write, req_cen, req_wdata,
        output req_done, req_err, req_rdata,
        output uart_rcen, uart_wcen, uart_wdata,
        input  uart_rack, uart_rdata, uart_wack, uart_interrupt,
        output irq_pending,
        input  irq_clear
    );

    modport master (
        output req_valid, req_write, req_cen, req_wdata,
        input  req_done, req_err, req_rdata,
        input  uart_rcen, uart_wcen, uart_wdata,
        output uart_rack, uart_rdata, uart_wack, uart_interrupt,
        input  irq_pending,
        output irq_clear
    );
endinterface

// File: rtl/ucore_uart_arbiter.sv
// Round-robin arbiter sharing the ucore UART read/write channel among NREQ requesters,
// one transaction in flight, strobe held until ack or timeout; plus sticky interrupt flag.
`timescale 1ns/1ps
module ucore_uart_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 reset,
    ucore_uart_arbiter_if.slave bus
);
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNTW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_e;

    state_e          state_q;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  id_q;
    logic [CNTW-1:0] cnt_q;
    logic [NREQ-1:0] req_done_q;
    logic            req_err_q;
    logic [7:0]      req_rdata_q;
    logic [7:0]      uart_rcen_q;
    logic [7:0]      uart_wcen_q;
    logic [7:0]      uart_wdata_q;
    logic            irq_sample_q;
    logic            irq_pending_q;

    logic            sel_any;
    logic [IDW-1:0]  sel_idx;
    logic [IDW-1:0]  cand;
    logic [7:0]      sel_cen;
    logic [7:0]      sel_wdata;
    logic            sel_write;
    logic [NREQ-1:0] sel_oh;
    logic [NREQ-1:0] id_oh;
    logic            timed_out;

    // Round-robin pick: scan upward from last_grant+1; the lowest offset wins.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            cand = IDW'((int'(last_grant_q) + k) % int'(NREQ));
            if (bus.req_valid[cand]) begin
                sel_any = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign sel_cen   = bus.req_cen[8*int'(sel_idx) +: 8];
    assign sel_wdata = bus.req_wdata[8*int'(sel_idx) +: 8];
    assign sel_write = bus.req_write[sel_idx];
    assign sel_oh    = NREQ'(1) << sel_idx;
    assign id_oh     = NREQ'(1) << id_q;
    assign timed_out = (cnt_q == CNTW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            cnt_q        <= '0;
            req_done_q   <= '0;
            req_err_q    <= 1'b0;
            req_rdata_q  <= '0;
            uart_rcen_q  <= '0;
            uart_wcen_q  <= '0;
            uart_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_any) begin
                        id_q         <= sel_idx;
                        last_grant_q <= sel_idx;
                        cnt_q        <= '0;
                        if (sel_cen == 8'h00) begin
                            // Nothing to strobe: complete immediately with an error.
                            state_q     <= ST_DONE;
                            req_done_q  <= sel_oh;
                            req_err_q   <= 1'b1;
                            req_rdata_q <= '0;
                        end else if (sel_write) begin
                            state_q      <= ST_WRITE;
                            uart_wcen_q  <= sel_cen;
                            uart_wdata_q <= sel_wdata;
                        end else begin
                            state_q     <= ST_READ;
                            uart_rcen_q <= sel_cen;
                        end
                    end
                end
                ST_READ: begin
                    if (bus.uart_rack) begin
                        state_q     <= ST_DONE;
                        uart_rcen_q <= '0;
                        req_done_q  <= id_oh;
                        req_err_q   <= 1'b0;
                        req_rdata_q <= bus.uart_rdata;
                    end else if (timed_out) begin
                        state_q     <= ST_DONE;
                        uart_rcen_q <= '0;
                        req_done_q  <= id_oh;
                        req_err_q   <= 1'b1;
                        req_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_WRITE: begin
                    if (bus.uart_wack || timed_out) begin
                        state_q      <= ST_DONE;
                        uart_wcen_q  <= '0;
                        uart_wdata_q <= '0;
                        req_done_q   <= id_oh;
                        req_err_q    <= ~bus.uart_wack;
                        req_rdata_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    req_done_q  <= '0;
                    req_err_q   <= 1'b0;
                    req_rdata_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky interrupt flag: a new rising edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_sample_q  <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            irq_sample_q <= bus.uart_interrupt;
            if (bus.uart_interrupt && !irq_sample_q) begin
                irq_pending_q <= 1'b1;
            end else if (bus.irq_clear) begin
                irq_pending_q <= 1'b0;
            end
        end
    end

    assign bus.req_done    = req_done_q;
    assign bus.req_err     = req_err_q;
    assign bus.req_rdata   = req_rdata_q;
    assign bus.uart_rcen   = uart_rcen_q;
    assign bus.uart_wcen   = uart_wcen_q;
    assign bus.uart_wdata  = uart_wdata_q;
    assign bus.irq_pending = irq_pending_q;
endmodule
